// File: rtl/fetch_queue_if.sv
// Fetch-to-decode instruction queue interface.
// The slave modport is the queue. The master modport is the fetch/decode side driving it.
//
// Handshake semantics:
// - Fetch side: an instruction transfers on a rising clk edge when in_valid && in_ready.
//   in_ready depends only on occupancy, never on in_valid or stallD.
// - Decode side: the head entry is consumed on a rising clk edge when validD && !stallD.
//   While stallD holds, the head outputs stay stable.
interface fetch_queue_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    // Fetch side
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_pc;
    logic [31:0]   in_instr;
    logic          in_adel;

    // Decode side
    logic          stallD;
    logic          validD;
    logic [31:0]   instrD;
    logic [31:0]   pcD;
    logic          adelD;
    logic [CW-1:0] count;

    modport slave (
        input  in_valid,
        input  in_pc,
        input  in_instr,
        input  in_adel,
        input  stallD,
        output in_ready,
        output validD,
        output instrD,
        output pcD,
        output adelD,
        output count
    );

    modport master (
        output in_valid,
        output in_pc,
        output in_instr,
        output in_adel,
        output stallD,
        input  in_ready,
        input  validD,
        input  instrD,
        input  pcD,
        input  adelD,
        input  count
    );
endinterface

// File: rtl/fetch_queue.sv
// Circular instruction queue between fetch and decode.
// Entries are {pc, instr, adel}. There is no bypass path, so a pushed entry is visible
// at the head no earlier than the cycle after the push. Flush empties the queue and
// takes priority over any same-cycle push or pop. While empty, the head outputs read
// as a NOP with a zero PC.
module fetch_queue #(
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          flush,
    fetch_queue_if.slave  q
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        adel;
    } entry_t;

    // Storage carries no reset; it is only ever read while count != 0.
    entry_t        mem [DEPTH];

    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [CW-1:0] cnt;

    logic          full;
    logic          valid;
    logic          push;
    logic          pop;
    entry_t        wr_entry;
    entry_t        head;

    // Pointer advance with an explicit wrap from DEPTH-1 back to 0.
    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return '0;
        end
        return p + PW'(1);
    endfunction

    assign full  = (cnt == CW'(DEPTH));
    assign valid = (cnt != '0);

    // Acceptance looks only at occupancy; a pop in the same cycle does not free a slot early.
    assign push = q.in_valid && !full && !flush;
    assign pop  = valid && !q.stallD && !flush;

    assign wr_entry = '{pc: q.in_pc, instr: q.in_instr, adel: q.in_adel};
    assign head     = mem[rptr];

    // Pointer and occupancy update. Flush wins over push and pop.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else if (flush) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (push) begin
                wptr <= ptr_next(wptr);
            end
            if (pop) begin
                rptr <= ptr_next(rptr);
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Entry write at the write pointer on an accepted push.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= wr_entry;
        end
    end

    // Head presentation. Outputs are forced to zero while the queue is empty.
    always_comb begin
        q.in_ready = !full;
        q.validD   = valid;
        q.count    = cnt;
        q.instrD   = 32'h0;
        q.pcD      = 32'h0;
        q.adelD    = 1'b0;
        if (valid) begin
            q.instrD = head.instr;
            q.pcD    = head.pc;
            q.adelD  = head.adel;
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue at DEPTH=4.
module tb_fetch_queue;
    localparam int DEPTH = 4;

    logic clk;
    logic resetn;
    logic flush;

    int tests;
    int fails;

    logic [31:0] exp_q[$];

    fetch_queue_if #(.DEPTH(DEPTH)) q ();

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk    (clk),
        .resetn (resetn),
        .flush  (flush),
        .q      (q.slave)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Checking task
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge; inputs are driven and outputs sampled 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Driver tasks
    task automatic drive_in(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                            input logic adel);
        q.in_valid = v;
        q.in_pc    = pc;
        q.in_instr = instr;
        q.in_adel  = adel;
    endtask

    task automatic idle_in();
        drive_in(1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    // Pops exp_q and compares it against the current head.
    task automatic check_head(input string tag);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL %s: expected queue empty while a head was checked", tag);
        end else begin
            e = exp_q.pop_front();
            check(tag, q.pcD, e);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        resetn = 1'b0;
        flush  = 1'b0;
        q.stallD = 1'b0;
        idle_in();

        // Reset state
        #12;
        check("rst_validD", 32'(q.validD), 32'd0);
        check("rst_instrD", q.instrD, 32'h0);
        check("rst_pcD", q.pcD, 32'h0);
        check("rst_adelD", 32'(q.adelD), 32'd0);
        check("rst_in_ready", 32'(q.in_ready), 32'd1);
        check("rst_count", 32'(q.count), 32'd0);
        resetn = 1'b1;
        step();

        // Single push, one-cycle latency, then pop
        drive_in(1'b1, 32'hBFC0_0000, 32'h2408_0001, 1'b0);
        #1;
        check("nobypass_validD", 32'(q.validD), 32'd0);
        step();
        idle_in();
        check("single_validD", 32'(q.validD), 32'd1);
        check("single_instrD", q.instrD, 32'h2408_0001);
        check("single_pcD", q.pcD, 32'hBFC0_0000);
        step();
        check("single_empty", 32'(q.validD), 32'd0);

        // Fill under stall, reject a 5th push, then drain in order
        q.stallD = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_in(1'b1, 32'h1000 + 32'(4 * i), 32'hA0 + 32'(i), 1'b0);
            exp_q.push_back(32'h1000 + 32'(4 * i));
            step();
        end
        check("fill_count", 32'(q.count), 32'd4);
        check("fill_in_ready", 32'(q.in_ready), 32'd0);
        check("fill_head_held", q.pcD, 32'h1000);
        drive_in(1'b1, 32'h2000, 32'hDEAD, 1'b0);
        step();
        check("overflow_count", 32'(q.count), 32'd4);
        check("overflow_head", q.pcD, 32'h1000);
        idle_in();
        q.stallD = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("drain_instr", q.instrD, 32'hA0 + 32'(i));
            check_head("drain_pc");
            step();
        end
        check("drain_empty", 32'(q.validD), 32'd0);
        check("drain_count", 32'(q.count), 32'd0);

        // Full queue: pop proceeds, push rejected
        q.stallD = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_in(1'b1, 32'h3000 + 32'(4 * i), 32'h0, 1'b0);
            step();
        end
        drive_in(1'b1, 32'h4000, 32'h0, 1'b0);
        q.stallD = 1'b0;
        #1;
        check("full_pop_in_ready", 32'(q.in_ready), 32'd0);
        step();
        idle_in();
        check("full_pop_count", 32'(q.count), 32'd3);
        exp_q.push_back(32'h3004);
        exp_q.push_back(32'h3008);
        exp_q.push_back(32'h300C);
        for (int i = 0; i < 3; i++) begin
            check_head("full_pop_drain");
            step();
        end
        check("full_pop_no_extra", 32'(q.validD), 32'd0);

        // Flush with a concurrent push
        q.stallD = 1'b1;
        drive_in(1'b1, 32'h5000, 32'h11, 1'b0);
        step();
        drive_in(1'b1, 32'h5004, 32'h12, 1'b0);
        step();
        check("preflush_count", 32'(q.count), 32'd2);
        drive_in(1'b1, 32'h5008, 32'h13, 1'b0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        idle_in();
        check("flush_count", 32'(q.count), 32'd0);
        check("flush_validD", 32'(q.validD), 32'd0);
        check("flush_instrD", q.instrD, 32'h0);
        step();
        check("flush_lost", 32'(q.validD), 32'd0);
        drive_in(1'b1, 32'h5100, 32'h14, 1'b0);
        step();
        idle_in();
        check("postflush_head", q.pcD, 32'h5100);
        check("postflush_count", 32'(q.count), 32'd1);
        q.stallD = 1'b0;
        step();

        // Continuous push and pop across pointer wrap
        drive_in(1'b1, 32'h6000, 32'h0, 1'b0);
        step();
        for (int k = 1; k <= 10; k++) begin
            drive_in(1'b1, 32'h6000 + 32'(4 * k), 32'h0, 1'b0);
            check("stream_count", 32'(q.count), 32'd1);
            check("stream_pc", q.pcD, 32'h6000 + 32'(4 * (k - 1)));
            step();
        end
        idle_in();
        check("stream_last", q.pcD, 32'h6028);
        step();
        check("stream_empty", 32'(q.validD), 32'd0);

        // Address-error flag, then asynchronous reset mid-stream
        q.stallD = 1'b1;
        drive_in(1'b1, 32'hBFC0_0001, 32'h0, 1'b1);
        step();
        drive_in(1'b1, 32'h7000, 32'h77, 1'b0);
        check("adel_flag", 32'(q.adelD), 32'd1);
        check("adel_pc", q.pcD, 32'hBFC0_0001);
        step();
        idle_in();
        check("adel_count", 32'(q.count), 32'd2);
        #1;
        resetn = 1'b0;
        #1;
        check("async_rst_validD", 32'(q.validD), 32'd0);
        check("async_rst_pcD", q.pcD, 32'h0);
        check("async_rst_adelD", 32'(q.adelD), 32'd0);
        check("async_rst_count", 32'(q.count), 32'd0);
        check("async_rst_in_ready", 32'(q.in_ready), 32'd1);
        #1;
        resetn = 1'b1;
        q.stallD = 1'b0;
        drive_in(1'b1, 32'h8000, 32'h88, 1'b0);
        step();
        idle_in();
        check("after_rst_head", q.pcD, 32'h8000);
        check("after_rst_instr", q.instrD, 32'h88);
        check("after_rst_count", 32'(q.count), 32'd1);
        step();
        check("after_rst_empty", 32'(q.validD), 32'd0);

        // Final report
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
